disparity_line_filter: RTL and testbench

//  Post-match cleanup stage between the disparity fifo_buffer read port and output_decoder.

---
 rtl/disparity_line_filter.sv | 121 ++++++++++++
 tb/tb_disparity_line_filter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/disparity_line_filter.sv
// Post-match cleanup: rejects weak matches by window_sum threshold, then applies a
// 3-tap horizontal median per image line with replicated edges.
module disparity_line_filter #(
  parameter int         LINE_WIDTH   = 320,
  parameter int         SUM_THRESH   = 4000,
  parameter logic [5:0] INVALID_DISP = 6'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        line_restart,
  input  logic        valid_in,
  input  logic [19:0] data_in,
  output logic        ready_out,
  output logic        valid_out,
  output logic [5:0]  disparity_out,
  output logic [9:0]  reject_count
);

  localparam int               COL_W    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FIRST, RUN, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [5:0]       prev, cur, prev_nxt, cur_nxt;
  logic             emit;
  logic [5:0]       emit_val;
  logic             accept, rejected;
  logic [5:0]       d;
  logic             clr_pending;
  logic [9:0]       rc_base, rc_nxt;

  function automatic logic [5:0] med3(input logic [5:0] a, input logic [5:0] b,
                                      input logic [5:0] c);
    logic [5:0] lo, hi, hc;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    hc = (hi < c) ? hi : c;
    return (lo > hc) ? lo : hc;
  endfunction

  assign ready_out = (state != FLUSH);
  assign accept    = valid_in && ready_out;
  assign rejected  = data_in[13:0] > 14'(SUM_THRESH);
  assign d         = rejected ? INVALID_DISP : data_in[19:14];

  // The line's count is cleared one cycle after FLUSH so it still reads correctly
  // alongside the last column's output.
  assign rc_base = (line_restart || clr_pending) ? 10'd0 : reject_count;
  assign rc_nxt  = (accept && rejected && rc_base != 10'h3FF) ? rc_base + 10'd1 : rc_base;

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    prev_nxt  = prev;
    cur_nxt   = cur;
    emit      = 1'b0;
    emit_val  = med3(prev, cur, cur);
    if (line_restart) begin
      prev_nxt  = 6'd0;
      cur_nxt   = accept ? d : 6'd0;
      col_nxt   = accept ? COL_W'(1) : '0;
      state_nxt = !accept ? IDLE : ((LINE_WIDTH == 1) ? FLUSH : FIRST);
    end else begin
      case (state)
        IDLE: if (accept) begin
          cur_nxt   = d;
          col_nxt   = COL_W'(1);
          state_nxt = (LINE_WIDTH == 1) ? FLUSH : FIRST;
        end
        FIRST: if (accept) begin
          emit      = 1'b1;
          emit_val  = med3(cur, cur, d);
          prev_nxt  = cur;
          cur_nxt   = d;
          col_nxt   = col + 1'b1;
          state_nxt = (col == LAST_COL) ? FLUSH : RUN;
        end
        RUN: if (accept) begin
          emit      = 1'b1;
          emit_val  = med3(prev, cur, d);
          prev_nxt  = cur;
          cur_nxt   = d;
          col_nxt   = col + 1'b1;
          state_nxt = (col == LAST_COL) ? FLUSH : RUN;
        end
        FLUSH: begin
          emit      = 1'b1;
          col_nxt   = '0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      col           <= '0;
      prev          <= 6'd0;
      cur           <= 6'd0;
      valid_out     <= 1'b0;
      disparity_out <= 6'd0;
      reject_count  <= 10'd0;
      clr_pending   <= 1'b0;
    end else begin
      state        <= state_nxt;
      col          <= col_nxt;
      prev         <= prev_nxt;
      cur          <= cur_nxt;
      valid_out    <= emit;
      if (emit)
        disparity_out <= emit_val;
      reject_count <= rc_nxt;
      clr_pending  <= (state == FLUSH) && !line_restart;
    end
  end

endmodule

// File: tb/tb_disparity_line_filter.sv
// Directed bench for disparity_line_filter with an 8-pixel line; outputs are
// collected by a monitor and compared against hand-computed medians.
module tb_disparity_line_filter;

  localparam int LW = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_restart = 1'b0;
  logic        valid_in = 1'b0;
  logic [19:0] data_in = '0;
  logic        ready_out, valid_out;
  logic [5:0]  disparity_out;
  logic [9:0]  reject_count;

  int total = 0;
  int bad = 0;
  logic [5:0] out_q[$];
  logic [9:0] rc_q[$];

  disparity_line_filter #(.LINE_WIDTH(LW), .SUM_THRESH(4000), .INVALID_DISP(6'd0)) dut (
    .clock(clock), .reset_n(reset_n), .line_restart(line_restart), .valid_in(valid_in),
    .data_in(data_in), .ready_out(ready_out), .valid_out(valid_out),
    .disparity_out(disparity_out), .reject_count(reject_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #2;
    if (valid_out) begin
      out_q.push_back(disparity_out);
      rc_q.push_back(reject_count);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, required completion");
    $fatal(1, "[TB] watchdog timeout");
  end

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [5:0] disp, input logic [13:0] ws);
    int waits = 0;
    valid_in = 1'b1;
    data_in  = {disp, ws};
    while (!ready_out && waits < 20) begin
      @(negedge clock);
      waits++;
    end
    if (!ready_out) begin
      total++; bad++;
      $display("[TB] FAIL send_ready: ready_out=%0b after %0d cycles, required 1", ready_out, waits);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid_out); end
    total++; if (disparity_out !== 6'd0) begin bad++; $display("[TB] FAIL reset_disp: got %0d expected 0", disparity_out); end
    total++; if (reject_count !== 10'd0) begin bad++; $display("[TB] FAIL reset_rc: got %0d expected 0", reject_count); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %0b expected 1", ready_out); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_ramp();
    out_q.delete(); rc_q.delete();
    for (int i = 0; i < LW; i++) send(6'(i), 14'd0);
    valid_in = 1'b0;
    total++; if (ready_out !== 1'b0) begin bad++; $display("[TB] FAIL ramp_flush_ready: got %0b expected 0", ready_out); end
    total++; if (valid_out !== 1'b1 || disparity_out !== 6'd6) begin bad++; $display("[TB] FAIL ramp_col6: got v=%0b d=%0d expected v=1 d=6", valid_out, disparity_out); end
    @(negedge clock);
    total++; if (ready_out !== 1'b1) begin bad++; $display("[TB] FAIL ramp_ready_back: got %0b expected 1", ready_out); end
    total++; if (valid_out !== 1'b1 || disparity_out !== 6'd7) begin bad++; $display("[TB] FAIL ramp_col7: got v=%0b d=%0d expected v=1 d=7", valid_out, disparity_out); end
    @(negedge clock);
    total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL ramp_quiet: got %0b expected 0", valid_out); end
    idle(2);
    total++; if (out_q.size() != LW) begin bad++; $display("[TB] FAIL ramp_count: got %0d expected %0d", out_q.size(), LW); end
    for (int i = 0; i < LW && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== 6'(i)) begin bad++; $display("[TB] FAIL ramp_out[%0d]: got %0d expected %0d", i, out_q[i], i); end
    end
  endtask

  task automatic test_impulse();
    logic [5:0] din[16];
    logic [5:0] exp_v[16];
    din   = '{5, 5, 40, 5, 5, 5, 5, 5, 9, 1, 1, 1, 1, 1, 1, 1};
    exp_v = '{5, 5, 5, 5, 5, 5, 5, 5, 9, 1, 1, 1, 1, 1, 1, 1};
    out_q.delete(); rc_q.delete();
    for (int i = 0; i < 16; i++) send(din[i], 14'd10);
    idle(4);
    total++; if (out_q.size() != 16) begin bad++; $display("[TB] FAIL impulse_count: got %0d expected 16", out_q.size()); end
    for (int i = 0; i < 16 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_v[i]) begin bad++; $display("[TB] FAIL impulse_out[%0d]: got %0d expected %0d", i, out_q[i], exp_v[i]); end
    end
  endtask

  task automatic test_threshold();
    logic [5:0]  din[8];
    logic [13:0] ws[8];
    logic [5:0]  exp_v[8];
    din   = '{12, 12, 12, 20, 20, 20, 20, 20};
    ws    = '{4000, 4001, 0, 16383, 100, 4001, 0, 0};
    exp_v = '{12, 12, 0, 12, 0, 20, 20, 20};
    out_q.delete(); rc_q.delete();
    for (int i = 0; i < 8; i++) send(din[i], ws[i]);
    idle(3);
    total++; if (reject_count !== 10'd0) begin bad++; $display("[TB] FAIL thresh_rc_cleared: got %0d expected 0", reject_count); end
    total++; if (out_q.size() != 8) begin bad++; $display("[TB] FAIL thresh_count: got %0d expected 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_v[i]) begin bad++; $display("[TB] FAIL thresh_out[%0d]: got %0d expected %0d", i, out_q[i], exp_v[i]); end
    end
    if (rc_q.size() == 8) begin
      total++; if (rc_q[0] !== 10'd1) begin bad++; $display("[TB] FAIL thresh_rc_first: got %0d expected 1", rc_q[0]); end
      total++; if (rc_q[7] !== 10'd3) begin bad++; $display("[TB] FAIL thresh_rc_last: got %0d expected 3", rc_q[7]); end
    end
  endtask

  task automatic test_gaps();
    out_q.delete(); rc_q.delete();
    for (int i = 0; i < LW; i++) begin
      send(6'(i), 14'd0);
      idle($urandom_range(0, 2));
    end
    idle(4);
    total++; if (out_q.size() != LW) begin bad++; $display("[TB] FAIL gaps_count: got %0d expected %0d", out_q.size(), LW); end
    for (int i = 0; i < LW && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== 6'(i)) begin bad++; $display("[TB] FAIL gaps_out[%0d]: got %0d expected %0d", i, out_q[i], i); end
    end
  endtask

  task automatic test_restart();
    logic [5:0] exp_v[11];
    exp_v = '{10, 11, 12, 30, 31, 32, 33, 34, 35, 36, 37};
    out_q.delete(); rc_q.delete();
    for (int i = 0; i < 4; i++) send(6'(10 + i), 14'd0);
    line_restart = 1'b1;
    send(6'd30, 14'd0);
    line_restart = 1'b0;
    total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL restart_no_output: got %0b expected 0", valid_out); end
    for (int i = 1; i < LW; i++) send(6'(30 + i), 14'd0);
    idle(4);
    total++; if (out_q.size() != 11) begin bad++; $display("[TB] FAIL restart_count: got %0d expected 11", out_q.size()); end
    for (int i = 0; i < 11 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_v[i]) begin bad++; $display("[TB] FAIL restart_out[%0d]: got %0d expected %0d", i, out_q[i], exp_v[i]); end
    end
  endtask

  task automatic test_reset_midline();
    send(6'd50, 14'd0);
    send(6'd51, 14'd5000);
    send(6'd52, 14'd0);
    total++; if (reject_count !== 10'd1) begin bad++; $display("[TB] FAIL midline_rc_before: got %0d expected 1", reject_count); end
    reset_n  = 1'b0;
    valid_in = 1'b1;
    data_in  = {6'd53, 14'd0};
    @(negedge clock);
    total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL midline_valid: got %0b expected 0", valid_out); end
    total++; if (disparity_out !== 6'd0) begin bad++; $display("[TB] FAIL midline_disp: got %0d expected 0", disparity_out); end
    total++; if (reject_count !== 10'd0) begin bad++; $display("[TB] FAIL midline_rc: got %0d expected 0", reject_count); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("[TB] FAIL midline_ready: got %0b expected 1", ready_out); end
    reset_n  = 1'b1;
    valid_in = 1'b0;
    @(negedge clock);
    out_q.delete(); rc_q.delete();
    for (int i = 0; i < LW; i++) send(6'(20 + i), 14'd0);
    for (int i = 0; i < LW; i++) send(6'(40 + i), 14'd0);
    idle(4);
    total++; if (out_q.size() != 2 * LW) begin bad++; $display("[TB] FAIL b2b_count: got %0d expected %0d", out_q.size(), 2 * LW); end
    for (int i = 0; i < 2 * LW && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== ((i < LW) ? 6'(20 + i) : 6'(40 + i - LW))) begin
        bad++;
        $display("[TB] FAIL b2b_out[%0d]: got %0d expected %0d", i, out_q[i], (i < LW) ? 20 + i : 40 + i - LW);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_impulse();
    test_threshold();
    test_gaps();
    test_restart();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
